// File: rtl/pong_bar_sched.sv
// pong_bar_sched: picks a bar move from either the Nios custom instruction
// (absolute Y) or the push-button stepper (relative steps). Each target is
// clamped, held for a settle delay, and committed only during vertical blank,
// so the bar never tears mid-frame.
module pong_bar_sched #(
  parameter int unsigned Y_INIT       = 195,
  parameter int unsigned Y_MIN        = 6,
  parameter int unsigned Y_MAX        = 382,
  parameter int unsigned STEP         = 8,
  parameter int unsigned DELAY_CYCLES = 1048575,
  parameter int unsigned COMMIT_LINE  = 480
) (
  input  logic       clk_in,
  input  logic       i_rst,
  input  logic       enablePong,
  input  logic       clk_en,
  input  logic       refreshBar,
  input  logic [8:0] coordY,
  input  logic       btn_req,
  input  logic       btn_dir,
  input  logic       o_active,
  input  logic [8:0] o_y,
  output logic [8:0] y_bar,
  output logic       ci_done,
  output logic       busy,
  output logic       commit,
  output logic       ovr
);

  typedef enum logic [1:0] {IDLE, DELAY, WAIT_BLANK, COMMIT} state_t;

  // The counter only ever needs to reach DELAY_CYCLES-1.
  localparam int unsigned CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((DELAY_CYCLES > 0) ? (DELAY_CYCLES - 1) : 0);

  localparam logic [9:0] Y_MIN_W  = 10'(Y_MIN);
  localparam logic [9:0] Y_MAX_W  = 10'(Y_MAX);
  localparam logic [9:0] STEP_W   = 10'(STEP);
  localparam logic [8:0] Y_MIN_N  = 9'(Y_MIN);
  localparam logic [8:0] Y_MAX_N  = 9'(Y_MAX);
  localparam logic [8:0] Y_INIT_N = 9'(Y_INIT);
  localparam logic [8:0] COMMIT_N = 9'(COMMIT_LINE);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             ci_pend;
  logic [8:0]       ci_val;
  logic             btn_pend;
  logic             btn_dir_q;
  logic             last_btn;
  logic [8:0]       tgt;
  logic [8:0]       tgt_calc;
  logic             grant_ci;
  logic             grant_btn;
  logic             ci_req;
  logic             blank;
  logic [9:0]       y_wide;
  logic [9:0]       ci_wide;

  assign ci_req  = clk_en & refreshBar;
  assign blank   = ~o_active & (o_y >= COMMIT_N);
  assign y_wide  = {1'b0, y_bar};
  assign ci_wide = {1'b0, ci_val};

  // State register; falls back to IDLE on reset.
  always_ff @(posedge clk_in or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and round-robin grant; disabling the game abandons any move.
  always_comb begin
    state_next = state;
    grant_ci   = 1'b0;
    grant_btn  = 1'b0;
    if (!enablePong) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (ci_pend && btn_pend) begin
            if (last_btn) begin
              grant_ci = 1'b1;
            end else begin
              grant_btn = 1'b1;
            end
          end else if (ci_pend) begin
            grant_ci = 1'b1;
          end else if (btn_pend) begin
            grant_btn = 1'b1;
          end
          if (grant_ci || grant_btn) begin
            state_next = (DELAY_CYCLES == 0) ? WAIT_BLANK : DELAY;
          end
        end
        DELAY: begin
          if (cnt == CNT_LAST) begin
            state_next = WAIT_BLANK;
          end
        end
        WAIT_BLANK: begin
          if (blank) begin
            state_next = COMMIT;
          end
        end
        COMMIT: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Clamped target for whichever requester is granted; buttons step from the live y_bar.
  always_comb begin
    tgt_calc = y_bar;
    if (grant_ci) begin
      if (ci_wide < Y_MIN_W) begin
        tgt_calc = Y_MIN_N;
      end else if (ci_wide > Y_MAX_W) begin
        tgt_calc = Y_MAX_N;
      end else begin
        tgt_calc = ci_val;
      end
    end else if (btn_dir_q) begin
      if (y_wide + STEP_W > Y_MAX_W) begin
        tgt_calc = Y_MAX_N;
      end else begin
        tgt_calc = 9'(y_wide + STEP_W);
      end
    end else begin
      if (y_wide < Y_MIN_W + STEP_W) begin
        tgt_calc = Y_MIN_N;
      end else begin
        tgt_calc = 9'(y_wide - STEP_W);
      end
    end
  end

  // Request capture, settle counter and the registered outputs.
  always_ff @(posedge clk_in or negedge i_rst) begin
    if (!i_rst) begin
      y_bar     <= Y_INIT_N;
      ci_done   <= 1'b0;
      busy      <= 1'b0;
      commit    <= 1'b0;
      ovr       <= 1'b0;
      ci_pend   <= 1'b0;
      ci_val    <= '0;
      btn_pend  <= 1'b0;
      btn_dir_q <= 1'b0;
      last_btn  <= 1'b1;
      cnt       <= '0;
      tgt       <= Y_INIT_N;
    end else begin
      ci_done <= ci_req;
      busy    <= (state_next != IDLE);
      commit  <= 1'b0;
      if (!enablePong) begin
        ci_pend  <= 1'b0;
        btn_pend <= 1'b0;
        cnt      <= '0;
      end else begin
        if (ci_req) begin
          ci_pend <= 1'b1;
          ci_val  <= coordY;
        end else if (grant_ci) begin
          ci_pend <= 1'b0;
        end
        if (btn_req && !btn_pend) begin
          btn_pend  <= 1'b1;
          btn_dir_q <= btn_dir;
        end else if (grant_btn) begin
          btn_pend <= 1'b0;
        end
        if (btn_req && btn_pend) begin
          ovr <= 1'b1;
        end
        if (grant_ci || grant_btn) begin
          tgt      <= tgt_calc;
          last_btn <= grant_btn;
          cnt      <= '0;
        end else if (state == DELAY) begin
          cnt <= cnt + 1'b1;
        end
        if ((state == WAIT_BLANK) && blank) begin
          y_bar  <= tgt;
          commit <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pong_bar_sched.sv
// tb_pong_bar_sched: directed stimulus for the bar scheduler, checked every
// cycle against a transaction-level model plus hand-computed expectations.
module tb_pong_bar_sched;

  localparam int DELAY  = 4;
  localparam int YMIN   = 6;
  localparam int YMAX   = 382;
  localparam int YSTEP  = 8;
  localparam int YINIT  = 195;
  localparam int CLINE  = 480;

  logic       clk_in = 1'b0;
  logic       i_rst;
  logic       enablePong;
  logic       clk_en;
  logic       refreshBar;
  logic [8:0] coordY;
  logic       btn_req;
  logic       btn_dir;
  logic       o_active;
  logic [8:0] o_y;
  logic [8:0] y_bar;
  logic       ci_done;
  logic       busy;
  logic       commit;
  logic       ovr;

  int tests_run    = 0;
  int tests_failed = 0;
  bit cmp_on       = 1'b0;

  pong_bar_sched #(.DELAY_CYCLES(DELAY)) dut (
    .clk_in(clk_in), .i_rst(i_rst), .enablePong(enablePong),
    .clk_en(clk_en), .refreshBar(refreshBar), .coordY(coordY),
    .btn_req(btn_req), .btn_dir(btn_dir), .o_active(o_active), .o_y(o_y),
    .y_bar(y_bar), .ci_done(ci_done), .busy(busy), .commit(commit), .ovr(ovr)
  );

  // Free-running board clock.
  always #5 clk_in = ~clk_in;

  // Model state: one move in flight at a time, settling then waiting for blank.
  int m_y, m_tgt, m_ci_val, m_left;
  bit m_ci_pend, m_btn_pend, m_btn_down, m_last_ci, m_inflight;
  bit m_commit, m_ci_done, m_ovr;
  bit g_ci, g_btn;
  int g_tgt;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Model decision: which request is served this cycle and where it lands.
  always @* begin
    g_ci  = 1'b0;
    g_btn = 1'b0;
    g_tgt = m_tgt;
    if (enablePong && !m_inflight && !m_commit) begin
      if (m_ci_pend && m_btn_pend) begin
        if (m_last_ci) g_btn = 1'b1;
        else g_ci = 1'b1;
      end else if (m_ci_pend) begin
        g_ci = 1'b1;
      end else if (m_btn_pend) begin
        g_btn = 1'b1;
      end
    end
    if (g_ci) g_tgt = imin(imax(m_ci_val, YMIN), YMAX);
    if (g_btn) g_tgt = m_btn_down ? imin(m_y + YSTEP, YMAX) : imax(m_y - YSTEP, YMIN);
  end

  // Model update per clock edge.
  always @(posedge clk_in or negedge i_rst) begin
    if (!i_rst) begin
      m_y <= YINIT; m_tgt <= YINIT; m_ci_val <= 0; m_left <= 0;
      m_ci_pend <= 1'b0; m_btn_pend <= 1'b0; m_btn_down <= 1'b0;
      m_last_ci <= 1'b0; m_inflight <= 1'b0; m_commit <= 1'b0;
      m_ci_done <= 1'b0; m_ovr <= 1'b0;
    end else begin
      m_ci_done <= clk_en & refreshBar;
      m_commit  <= 1'b0;
      if (!enablePong) begin
        m_ci_pend  <= 1'b0;
        m_btn_pend <= 1'b0;
        m_inflight <= 1'b0;
      end else begin
        if (clk_en && refreshBar) begin
          m_ci_pend <= 1'b1;
          m_ci_val  <= int'(coordY);
        end else if (g_ci) begin
          m_ci_pend <= 1'b0;
        end
        if (btn_req && m_btn_pend) m_ovr <= 1'b1;
        if (btn_req && !m_btn_pend) begin
          m_btn_pend <= 1'b1;
          m_btn_down <= btn_dir;
        end else if (g_btn) begin
          m_btn_pend <= 1'b0;
        end
        if (g_ci || g_btn) begin
          m_inflight <= 1'b1;
          m_left     <= DELAY;
          m_tgt      <= g_tgt;
          m_last_ci  <= g_ci;
        end else if (m_inflight) begin
          if (m_left > 0) begin
            m_left <= m_left - 1;
          end else if (!o_active && int'(o_y) >= CLINE) begin
            m_y        <= m_tgt;
            m_commit   <= 1'b1;
            m_inflight <= 1'b0;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk_in) begin
    if (cmp_on) begin
      checkOutput("model y_bar", 32'(y_bar), 32'(m_y));
      checkOutput("model ci_done", 32'(ci_done), 32'(m_ci_done));
      checkOutput("model busy", 32'(busy), 32'(m_inflight | m_commit));
      checkOutput("model commit", 32'(commit), 32'(m_commit));
      checkOutput("model ovr", 32'(ovr), 32'(m_ovr));
    end
  end

  // Present one request for exactly one sampling edge; returns 1 time unit after it.
  task automatic applyStimulus(input logic ci, input logic [8:0] y,
                               input logic b, input logic d);
    @(posedge clk_in); #1;
    clk_en = ci; refreshBar = ci; coordY = y; btn_req = b; btn_dir = d;
    @(posedge clk_in); #1;
    clk_en = 1'b0; refreshBar = 1'b0; btn_req = 1'b0;
  endtask

  task automatic waitCommit(input string name, input int limit);
    int n = 0;
    @(negedge clk_in);
    while (commit !== 1'b1 && n < limit) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput(name, 32'(commit), 32'd1);
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    @(negedge clk_in);
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("idle timeout", 32'(busy), 32'd0);
  endtask

  task automatic setBlank(input logic on);
    o_active = ~on;
    o_y      = on ? 9'd480 : 9'd100;
  endtask

  initial begin
    i_rst = 1'b1; enablePong = 1'b1; clk_en = 1'b0; refreshBar = 1'b0;
    coordY = '0; btn_req = 1'b0; btn_dir = 1'b0;
    setBlank(1'b0);
    #2 i_rst = 1'b0;
    #1 cmp_on = 1'b1;
    #20 i_rst = 1'b1;

    // Reset and idle.
    repeat (10) @(posedge clk_in);
    #1;
    checkOutput("reset y_bar", 32'(y_bar), 32'd195);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset commit", 32'(commit), 32'd0);
    checkOutput("reset ovr", 32'(ovr), 32'd0);

    // CI to 300 while drawing, blank released much later.
    applyStimulus(1'b1, 9'd300, 1'b0, 1'b0);
    checkOutput("ci_done pulse", 32'(ci_done), 32'd1);
    checkOutput("busy before grant", 32'(busy), 32'd0);
    @(posedge clk_in); #1;
    checkOutput("ci_done one cycle", 32'(ci_done), 32'd0);
    checkOutput("busy after grant", 32'(busy), 32'd1);
    repeat (20) @(posedge clk_in);
    #1;
    checkOutput("held during active", 32'(y_bar), 32'd195);
    setBlank(1'b1);
    @(negedge clk_in);
    checkOutput("no commit before edge", 32'(commit), 32'd0);
    @(negedge clk_in);
    checkOutput("commit first blank", 32'(commit), 32'd1);
    checkOutput("ci 300", 32'(y_bar), 32'd300);
    waitIdle(10);

    // Clamping of out-of-range CI targets.
    applyStimulus(1'b1, 9'd2, 1'b0, 1'b0);
    waitCommit("commit ci 2", 40);
    checkOutput("ci clamp low", 32'(y_bar), 32'd6);
    applyStimulus(1'b1, 9'd450, 1'b0, 1'b0);
    waitCommit("commit ci 450", 40);
    checkOutput("ci clamp high", 32'(y_bar), 32'd382);

    // Button stepping and overflow.
    applyStimulus(1'b1, 9'd10, 1'b0, 1'b0);
    waitCommit("commit ci 10", 40);
    checkOutput("ci 10", 32'(y_bar), 32'd10);
    applyStimulus(1'b0, 9'd0, 1'b1, 1'b0);
    waitCommit("commit btn up", 40);
    checkOutput("btn up clamp", 32'(y_bar), 32'd6);
    applyStimulus(1'b0, 9'd0, 1'b1, 1'b1);
    repeat (2) @(posedge clk_in);
    applyStimulus(1'b0, 9'd0, 1'b1, 1'b1);
    waitCommit("commit down 1", 40);
    checkOutput("btn down 1", 32'(y_bar), 32'd14);
    repeat (2) @(posedge clk_in);
    applyStimulus(1'b0, 9'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 9'd0, 1'b1, 1'b1);
    checkOutput("ovr on drop", 32'(ovr), 32'd1);
    waitCommit("commit down 2", 40);
    checkOutput("btn down 2", 32'(y_bar), 32'd22);
    waitCommit("commit down 3", 40);
    checkOutput("btn down 3", 32'(y_bar), 32'd30);
    waitIdle(20);
    checkOutput("no 4th step", 32'(y_bar), 32'd30);
    checkOutput("ovr sticky", 32'(ovr), 32'd1);

    // Reset, then a simultaneous CI and button: CI wins the first tie.
    @(posedge clk_in); #2 i_rst = 1'b0;
    #1;
    checkOutput("async reset y_bar", 32'(y_bar), 32'd195);
    checkOutput("reset clears ovr", 32'(ovr), 32'd0);
    #5 i_rst = 1'b1;
    applyStimulus(1'b1, 9'd200, 1'b1, 1'b1);
    waitCommit("commit tie ci", 40);
    checkOutput("tie ci first", 32'(y_bar), 32'd200);
    waitCommit("commit tie btn", 40);
    checkOutput("tie btn second", 32'(y_bar), 32'd208);
    waitIdle(10);

    // Game disabled during DELAY abandons the move.
    setBlank(1'b0);
    applyStimulus(1'b1, 9'd100, 1'b0, 1'b0);
    repeat (2) @(posedge clk_in);
    #1 enablePong = 1'b0;
    @(posedge clk_in); #1 enablePong = 1'b1;
    checkOutput("disable idles fsm", 32'(busy), 32'd0);
    setBlank(1'b1);
    repeat (10) @(posedge clk_in);
    #1;
    checkOutput("abandoned target", 32'(y_bar), 32'd208);

    // CI while disabled still completes but never moves the bar.
    enablePong = 1'b0;
    applyStimulus(1'b1, 9'd50, 1'b0, 1'b0);
    checkOutput("ci_done when disabled", 32'(ci_done), 32'd1);
    @(posedge clk_in); #1;
    enablePong = 1'b1;
    checkOutput("disabled stays idle", 32'(busy), 32'd0);
    repeat (8) @(posedge clk_in);
    #1;
    checkOutput("disabled ci ignored", 32'(y_bar), 32'd208);

    // Async reset while waiting for blank.
    setBlank(1'b0);
    applyStimulus(1'b1, 9'd100, 1'b0, 1'b0);
    repeat (8) @(posedge clk_in);
    #1;
    checkOutput("waiting for blank", 32'(busy), 32'd1);
    #2 i_rst = 1'b0;
    #1;
    checkOutput("reset mid wait y_bar", 32'(y_bar), 32'd195);
    checkOutput("reset mid wait busy", 32'(busy), 32'd0);
    #5 i_rst = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    cmp_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pong_bar_sched.md
Name: pong_bar_sched

Overview:
- Sequences every position update of the Pong paddle-bar renderer.
- Arbitrates between two requesters: the Nios custom instruction, which supplies an absolute Y, and the push-button stepper, which supplies relative up/down steps.
- Clamps each target, enforces a settle delay, then commits the new y_bar only while no visible pixel is being drawn, so the bar never tears mid-frame.
- Its y_bar output feeds the bar renderer and the ball collision logic.

Parameters:
- Y_INIT, 195: y_bar reset value.
- Y_MIN, 6: lowest legal bar Y.
- Y_MAX, 382: highest legal bar Y.
- STEP, 8: button step in lines.
- DELAY_CYCLES, 1048575: settle cycles between grant and blank wait (0 = skip).
- COMMIT_LINE, 480: first o_y line counted as vertical blank.

Ports:
- clk_in  input  1  board clock; the only clock.
- i_rst  input  1  asynchronous, active-low reset.
- enablePong  input  1  game enable.
- clk_en  input  1  custom-instruction strobe.
- refreshBar  input  1  CI request qualifier; a CI request is clk_en & refreshBar.
- coordY  input  9  CI absolute target.
- btn_req  input  1  one-cycle button request pulse.
- btn_dir  input  1  0 = up (decrease Y), 1 = down.
- o_active  input  1  video active area.
- o_y  input  9  current scan line.
- y_bar  output  9  committed bar Y.
- ci_done  output  1  one-cycle CI completion pulse.
- busy  output  1  high while the FSM is outside IDLE.
- commit  output  1  one-cycle pulse when y_bar updates.
- ovr  output  1  sticky flag: button request dropped.

Behaviour:
- Reset (i_rst=0, async) values:
  - y_bar=Y_INIT; ci_done=busy=commit=ovr=0.
  - Both pending flags clear; FSM=IDLE; delay counter=0.
  - last_grant=BTN, so CI wins the first tie.
- All outputs are registered.
- CI capture:
  - A CI request at edge t sets ci_pend and ci_val=coordY at t+1, and ci_done=1 for the cycle after t only.
  - A new CI while ci_pend is set overwrites ci_val; it is not counted as a drop.
- Button capture:
  - btn_req sets btn_pend and btn_dir_q.
  - btn_req while btn_pend is set is dropped and sets ovr; ovr clears only on reset.
- FSM states: IDLE, DELAY, WAIT_BLANK, COMMIT.
  - IDLE: if any pending, grant it. If both are pending, grant the requester that is not last_grant (round-robin).
    - Compute tgt and clear the granted pending flag.
    - Update last_grant, reset the counter, go to DELAY (or to WAIT_BLANK if DELAY_CYCLES=0).
    - A request captured in the same cycle is seen next cycle.
  - DELAY: counter increments each cycle. When counter==DELAY_CYCLES-1, go to WAIT_BLANK.
  - WAIT_BLANK: when o_active==0 and o_y>=COMMIT_LINE, go to COMMIT. Otherwise hold indefinitely.
  - COMMIT: y_bar<=tgt, commit=1 for this single cycle, then go to IDLE.
- Target arithmetic (10-bit internal):
  - CI target: clamp(coordY, Y_MIN, Y_MAX); out-of-range values are clamped, not ignored.
  - Button up: y_bar<Y_MIN+STEP gives Y_MIN, else y_bar-STEP.
  - Button down: y_bar+STEP>Y_MAX gives Y_MAX, else y_bar+STEP.
  - The button base is y_bar at grant time, not any pending target.
- Requests arriving during DELAY/WAIT_BLANK stay pending and are served after COMMIT. At most one update commits per pass through IDLE.
- enablePong=0:
  - Requests are ignored and pendings cleared.
  - The FSM returns to IDLE on the next edge, abandoning any in-flight target.
  - y_bar holds; ci_done still pulses for a CI so Nios never stalls.
- busy = (state != IDLE).

Test Plan:
- Reset, then idle 10 cycles -> y_bar=195, busy=0, commit=0, ovr=0.
- DELAY_CYCLES=4; CI coordY=300 while o_active=1; release blank 20 cycles later -> ci_done 1 cycle, busy set, commit in the first blank cycle after DELAY, y_bar=300.
- CI coordY=2, then CI coordY=450 -> y_bar=6, then y_bar=382.
- y_bar=10, btn up -> y_bar=6. Then btn down x3 with blank asserted -> 14, 22, 30; a 4th btn_req while btn_pend is set -> dropped, ovr=1.
- CI(200) and btn down issued in the same cycle from y_bar=195, blank held -> CI granted first (y_bar=200), then button (y_bar=208).
- CI(100) granted, enablePong dropped during DELAY -> FSM to IDLE, no commit, y_bar unchanged. Async reset asserted mid-WAIT_BLANK -> y_bar=195 immediately.
